// File: rtl/fpsu_pkg.sv
// Shared constants and stage record for the FP SIMD add/sub side-band pipe.
// Latency: n/a (types only).  Backpressure: n/a.
// Defaults here set the parameter defaults of fpsu_op_lane and fpsu_op_pipe.
package fpsu_pkg;

    localparam int RET_W       = 14;
    localparam int SIMD_HALF_W = 68;
    localparam int ADD_BIT_DEF = 10;
    localparam int OP_W_DEF    = 21;

    typedef struct packed {
        logic                v;
        logic [OP_W_DEF-1:0] op;
        logic                xsub;
        logic [RET_W-1:0]    tag;
    } fpsu_stage_t;

endpackage

// File: rtl/fpsu_op_lane.sv
// One issue port: DEPTH-entry shift pipe of {v, op, xsub, tag} with occupancy count and retire qualification.
// Latency: DEPTH cycles issue to retire strobe, plus one per stall cycle.
// Backpressure: stall holds every stage; kill flushes all stages and refuses issue.
module fpsu_op_lane
    import fpsu_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int OPW     = OP_W_DEF,
    parameter int TAGW    = RET_W,
    parameter int ADD_BIT = ADD_BIT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_en,
    input  logic [OPW-1:0]             in_op,
    input  logic                       in_xsub,
    input  logic [TAGW-1:0]            in_tag,
    input  logic                       stall,
    input  logic                       kill,
    output logic                       in_rdy,
    output logic                       out_en,
    output logic [OPW-1:0]             out_op,
    output logic [TAGW-1:0]            out_tag,
    output logic                       addbit,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       err
);

    localparam int OCW = $clog2(DEPTH+1);

    typedef struct packed {
        logic            v;
        logic [OPW-1:0]  op;
        logic            xsub;
        logic [TAGW-1:0] tag;
    } stage_t;

    stage_t          st_q [DEPTH];
    stage_t          fin;
    logic [OCW-1:0]  occ_q;
    logic            err_q;
    logic            advance;
    logic            accept;
    logic            any_v;

    assign advance = ~stall & ~kill;
    assign in_rdy  = advance;
    assign accept  = in_en & advance;
    assign fin     = st_q[DEPTH-1];

    // Whole-record shift: xsub moves with its op, so the final stage always carries the issue-time qualifier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i] <= '0;
            end
        end else if (kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i].v <= 1'b0;
            end
        end else if (!stall) begin
            st_q[0] <= '{v: in_en, op: in_op, xsub: in_xsub, tag: in_tag};
            for (int i = 1; i < DEPTH; i++) begin
                st_q[i] <= st_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (in_en & ~in_rdy);
            if (kill) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_q + OCW'(accept) - OCW'(out_en);
            end
        end
    end

    always_comb begin
        any_v = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_v = any_v | st_q[i].v;
        end
    end

    // Retire qualification; payload of an empty or held final stage is forced to zero.
    assign out_en  = fin.v & ~stall & ~kill;
    assign out_op  = out_en ? fin.op  : '0;
    assign out_tag = out_en ? fin.tag : '0;
    assign addbit  = out_en & fin.op[ADD_BIT] & ~fin.xsub;
    assign busy    = any_v & ~kill;
    assign occ     = occ_q;
    assign err     = err_q;

endmodule

// File: rtl/fpsu_op_pipe.sv
// Side-band op pipe for the FP SIMD add/sub cluster: NPORT independent lanes, add-not-sub broadcast, sticky issue error.
// Latency: DEPTH cycles issue to out_en per port, plus one per stall cycle of that port.
// Backpressure: in_rdy = ~stall & ~kill per port; issue while not ready is dropped and sets err.
module fpsu_op_pipe
    import fpsu_pkg::*;
#(
    parameter int NPORT   = 3,
    parameter int DEPTH   = 3,
    parameter int OPW     = OP_W_DEF,
    parameter int TAGW    = RET_W,
    parameter int ADD_BIT = ADD_BIT_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NPORT-1:0]                 in_en,
    input  logic [NPORT*OPW-1:0]             in_op,
    input  logic [NPORT-1:0]                 in_xsub,
    input  logic [NPORT*TAGW-1:0]            in_tag,
    input  logic [NPORT-1:0]                 stall,
    input  logic [NPORT-1:0]                 kill,
    output logic [NPORT-1:0]                 in_rdy,
    output logic [NPORT-1:0]                 out_en,
    output logic [NPORT*OPW-1:0]             out_op,
    output logic [NPORT*TAGW-1:0]            out_tag,
    output logic [NPORT-1:0]                 addmask,
    output logic [NPORT-1:0]                 busy,
    output logic [NPORT*$clog2(DEPTH+1)-1:0] occ,
    output logic                             err
);

    localparam int OCW = $clog2(DEPTH+1);

    logic [NPORT-1:0] lane_err;
    logic [NPORT-1:0] lane_add;

    for (genvar p = 0; p < NPORT; p++) begin : g_lane
        fpsu_op_lane #(
            .DEPTH   (DEPTH),
            .OPW     (OPW),
            .TAGW    (TAGW),
            .ADD_BIT (ADD_BIT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .in_en   (in_en[p]),
            .in_op   (in_op[p*OPW +: OPW]),
            .in_xsub (in_xsub[p]),
            .in_tag  (in_tag[p*TAGW +: TAGW]),
            .stall   (stall[p]),
            .kill    (kill[p]),
            .in_rdy  (in_rdy[p]),
            .out_en  (out_en[p]),
            .out_op  (out_op[p*OPW +: OPW]),
            .out_tag (out_tag[p*TAGW +: TAGW]),
            .addbit  (lane_add[p]),
            .busy    (busy[p]),
            .occ     (occ[p*OCW +: OCW]),
            .err     (lane_err[p])
        );
    end

    // One vector drives every port of both SIMD halves.
    assign addmask = lane_add;
    assign err     = |lane_err;

endmodule

// File: tb/tb_fpsu_op_pipe.sv
// Self-checking bench for fpsu_op_pipe (NPORT=3, DEPTH=3): per-port retire scoreboard plus scenario tasks.
module tb_fpsu_op_pipe;

    localparam int NP   = 3;
    localparam int DP   = 3;
    localparam int OPW  = 21;
    localparam int TAGW = 14;
    localparam int ABIT = 10;
    localparam int OCW  = $clog2(DP+1);

    localparam logic [OPW-1:0] OP_ADD = 21'h000400;
    localparam logic [OPW-1:0] OP_SUB = 21'h000013;

    logic                 clk;
    logic                 rst;
    logic [NP-1:0]        in_en;
    logic [NP*OPW-1:0]    in_op;
    logic [NP-1:0]        in_xsub;
    logic [NP*TAGW-1:0]   in_tag;
    logic [NP-1:0]        stall;
    logic [NP-1:0]        kill;
    logic [NP-1:0]        in_rdy;
    logic [NP-1:0]        out_en;
    logic [NP*OPW-1:0]    out_op;
    logic [NP*TAGW-1:0]   out_tag;
    logic [NP-1:0]        addmask;
    logic [NP-1:0]        busy;
    logic [NP*OCW-1:0]    occ;
    logic                 err;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [OPW-1:0]  op;
        logic            am;
    } exp_t;

    exp_t          sbq [NP][$];
    int            n_tests;
    int            n_fail;
    int            cyc;
    int            ret_cnt [NP];
    int            last_ret_cyc [NP];
    logic [NP-1:0] last_oe;
    logic [NP-1:0] last_am;

    fpsu_op_pipe #(
        .NPORT   (NP),
        .DEPTH   (DP),
        .OPW     (OPW),
        .TAGW    (TAGW),
        .ADD_BIT (ABIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_en   (in_en),
        .in_op   (in_op),
        .in_xsub (in_xsub),
        .in_tag  (in_tag),
        .stall   (stall),
        .kill    (kill),
        .in_rdy  (in_rdy),
        .out_en  (out_en),
        .out_op  (out_op),
        .out_tag (out_tag),
        .addmask (addmask),
        .busy    (busy),
        .occ     (occ),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_in();
        in_en   = '0;
        in_op   = '0;
        in_xsub = '0;
        in_tag  = '0;
    endtask

    task automatic set_issue(input int p, input logic [OPW-1:0] op, input logic xs, input logic [TAGW-1:0] tag);
        in_en[p]              = 1'b1;
        in_op[p*OPW +: OPW]   = op;
        in_xsub[p]            = xs;
        in_tag[p*TAGW +: TAGW] = tag;
    endtask

    // Scoreboard at negedge: pop and compare retirements, then push accepted issues; then advance one edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_oe = out_en;
        last_am = addmask;
        for (int p = 0; p < NP; p++) begin
            n_tests++;
            if (out_en[p]) begin
                if (sbq[p].size() == 0) begin
                    n_fail++;
                    $display("FAIL retire_unexpected port%0d: got tag %h, want no retire", p, out_tag[p*TAGW +: TAGW]);
                end else begin
                    e = sbq[p].pop_front();
                    if (out_tag[p*TAGW +: TAGW] !== e.tag || out_op[p*OPW +: OPW] !== e.op || addmask[p] !== e.am) begin
                        n_fail++;
                        $display("FAIL retire_data port%0d: got tag %h op %h am %b, want tag %h op %h am %b",
                                 p, out_tag[p*TAGW +: TAGW], out_op[p*OPW +: OPW], addmask[p], e.tag, e.op, e.am);
                    end
                    ret_cnt[p]++;
                    last_ret_cyc[p] = cyc;
                end
            end else if (out_op[p*OPW +: OPW] !== '0 || out_tag[p*TAGW +: TAGW] !== '0 || addmask[p] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_leak port%0d: got op %h tag %h am %b, want zeros",
                         p, out_op[p*OPW +: OPW], out_tag[p*TAGW +: TAGW], addmask[p]);
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (rst && in_en[p] && in_rdy[p]) begin
                e.tag = in_tag[p*TAGW +: TAGW];
                e.op  = in_op[p*OPW +: OPW];
                e.am  = in_op[p*OPW + ABIT] & ~in_xsub[p];
                sbq[p].push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stall = '0;
        kill = '0;
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (out_en !== '0 || addmask !== '0 || busy !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: got out_en %b addmask %b busy %b, want 000", out_en, addmask, busy);
        end
        n_tests++;
        if (occ !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_occ_err: got occ %h err %b, want 0 0", occ, err);
        end
        n_tests++;
        if (out_op !== '0 || out_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got op %h tag %h, want 0", out_op, out_tag);
        end
        stall = 3'b010;
        #1;
        n_tests++;
        if (in_rdy !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_rdy_stall: got %b, want 101", in_rdy);
        end
        kill = 3'b100;
        #1;
        n_tests++;
        if (in_rdy !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_rdy_kill: got %b, want 001", in_rdy);
        end
        stall = '0;
        kill = '0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int base;
        int icyc;
        bit found;
        clear_in();
        set_issue(0, OP_ADD, 1'b0, 14'h155);
        base = ret_cnt[0];
        icyc = cyc;
        tick();
        clear_in();
        n_tests++;
        if (occ[0 +: OCW] !== OCW'(1)) begin
            n_fail++;
            $display("FAIL single_occ1: got %0d, want 1", occ[0 +: OCW]);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ret_cnt[0] != base) found = 1'b1;
        end
        n_tests++;
        if (!found || last_ret_cyc[0] - icyc != DP) begin
            n_fail++;
            $display("FAIL single_latency: got found=%0d latency %0d, want latency %0d", found, last_ret_cyc[0] - icyc, DP);
        end
        n_tests++;
        if (last_am !== 3'b001) begin
            n_fail++;
            $display("FAIL single_addmask: got %b, want 001", last_am);
        end
        n_tests++;
        if (occ[0 +: OCW] !== '0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_occ0: got occ %0d busy %b, want 0 0", occ[0 +: OCW], busy[0]);
        end
        tick();
        n_tests++;
        if (last_oe[0] !== 1'b0 || ret_cnt[0] != base + 1) begin
            n_fail++;
            $display("FAIL single_pulse: got oe %b retires %0d, want 0 1", last_oe[0], ret_cnt[0] - base);
        end
    endtask

    task automatic test_xsub_b2b();
        logic [1:0] hist;
        int         n;
        clear_in();
        set_issue(0, OP_ADD, 1'b0, 14'h0A1);
        tick();
        clear_in();
        set_issue(0, OP_ADD, 1'b1, 14'h0B2);
        tick();
        clear_in();
        hist = '0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_oe[0] && n < 2) begin
                hist[1-n] = last_am[0];
                n++;
            end
        end
        n_tests++;
        if (n != 2 || hist !== 2'b10) begin
            n_fail++;
            $display("FAIL xsub_b2b: got %0d retires addmask seq %b, want 2 retires seq 10", n, hist);
        end
    endtask

    task automatic test_stall();
        int base;
        int issued;
        int peak;
        base = ret_cnt[1];
        issued = 0;
        peak = 0;
        for (int t = 0; t < 20 && ret_cnt[1] - base < 5; t++) begin
            clear_in();
            stall = (t == 2 || t == 3) ? 3'b010 : 3'b000;
            if (stall[1]) begin
                #1;
                n_tests++;
                if (in_rdy[1] !== 1'b0 || out_en[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_rdy: got in_rdy %b out_en %b, want 0 0", in_rdy[1], out_en[1]);
                end
            end else if (issued < 5) begin
                set_issue(1, OP_ADD | OPW'(issued), issued[0], TAGW'('h200 + issued));
                issued++;
            end
            tick();
            if (int'(occ[OCW +: OCW]) > peak) peak = int'(occ[OCW +: OCW]);
        end
        stall = '0;
        clear_in();
        n_tests++;
        if (ret_cnt[1] - base != 5 || sbq[1].size() != 0) begin
            n_fail++;
            $display("FAIL stall_count: got %0d retires, %0d pending, want 5 0", ret_cnt[1] - base, sbq[1].size());
        end
        n_tests++;
        if (peak != 3) begin
            n_fail++;
            $display("FAIL stall_peak_occ: got %0d, want 3", peak);
        end
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_err: got %b, want 0", err);
        end
    endtask

    task automatic test_kill();
        int base;
        base = ret_cnt[2];
        for (int i = 0; i < 3; i++) begin
            clear_in();
            set_issue(2, OP_ADD, 1'b0, TAGW'('h300 + i));
            tick();
        end
        clear_in();
        n_tests++;
        if (occ[2*OCW +: OCW] !== OCW'(3)) begin
            n_fail++;
            $display("FAIL kill_pre_occ: got %0d, want 3", occ[2*OCW +: OCW]);
        end
        set_issue(2, OP_ADD, 1'b0, 14'h3FF);
        kill = 3'b100;
        #1;
        n_tests++;
        if (out_en[2] !== 1'b0 || busy[2] !== 1'b0 || addmask[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_cycle: got out_en %b busy %b am %b, want 0 0 0", out_en[2], busy[2], addmask[2]);
        end
        sbq[2].delete();
        tick();
        kill = '0;
        clear_in();
        n_tests++;
        if (occ[2*OCW +: OCW] !== '0) begin
            n_fail++;
            $display("FAIL kill_occ: got %0d, want 0", occ[2*OCW +: OCW]);
        end
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_err: got %b, want 1", err);
        end
        repeat (6) tick();
        n_tests++;
        if (ret_cnt[2] != base) begin
            n_fail++;
            $display("FAIL kill_no_retire: got %0d retires, want 0", ret_cnt[2] - base);
        end
    endtask

    task automatic test_simul();
        bit found;
        clear_in();
        set_issue(0, OP_ADD, 1'b0, 14'h011);
        set_issue(1, OP_ADD, 1'b1, 14'h012);
        set_issue(2, OP_SUB, 1'b0, 14'h013);
        tick();
        clear_in();
        set_issue(0, OP_SUB, 1'b1, 14'h021);
        set_issue(1, OP_ADD, 1'b0, 14'h022);
        set_issue(2, OP_ADD | 21'h1, 1'b0, 14'h023);
        tick();
        clear_in();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (last_oe === 3'b111) found = 1'b1;
        end
        n_tests++;
        if (!found || last_am !== 3'b001) begin
            n_fail++;
            $display("FAIL simul_first: got found=%0d addmask %b, want 1 001", found, last_am);
        end
        tick();
        n_tests++;
        if (last_oe !== 3'b111 || last_am !== 3'b110) begin
            n_fail++;
            $display("FAIL simul_second: got out_en %b addmask %b, want 111 110", last_oe, last_am);
        end
    endtask

    task automatic test_rst_mid();
        int tot;
        tot = ret_cnt[0] + ret_cnt[1] + ret_cnt[2];
        for (int i = 0; i < 2; i++) begin
            clear_in();
            for (int p = 0; p < NP; p++) set_issue(p, OP_ADD, 1'b0, TAGW'('h400 + 16*p + i));
            tick();
        end
        clear_in();
        for (int p = 0; p < NP; p++) set_issue(p, OP_ADD, 1'b0, TAGW'('h4F0 + p));
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_en !== '0 || busy !== '0 || addmask !== '0 || occ !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_flags: got out_en %b busy %b am %b occ %h, want zeros", out_en, busy, addmask, occ);
        end
        n_tests++;
        if (out_tag !== '0 || out_op !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_payload: got tag %h op %h err %b, want zeros", out_tag, out_op, err);
        end
        for (int p = 0; p < NP; p++) sbq[p].delete();
        clear_in();
        tick();
        tick();
        rst = 1'b1;
        repeat (10) tick();
        n_tests++;
        if (ret_cnt[0] + ret_cnt[1] + ret_cnt[2] != tot || busy !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_no_retire: got %0d retires busy %b, want 0 000",
                     ret_cnt[0] + ret_cnt[1] + ret_cnt[2] - tot, busy);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        last_oe = '0;
        last_am = '0;
        for (int p = 0; p < NP; p++) begin
            ret_cnt[p]      = 0;
            last_ret_cyc[p] = 0;
        end
        test_reset();
        test_single();
        test_xsub_b2b();
        test_stall();
        test_kill();
        test_simul();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
